// File: rtl/exception_pkg.sv
// ----------------------------------------------------------------------------
// exception_pkg
// Shared types and constants for the LEGv8 exception controller.
//   exc_state_t    : controller FSM states (RUN, ACK, HANDLER)
//   ESEL_*         : EDataSel encodings for exception-register reads
//   EXC_VEC_BASE   : default vector address of source 0
//   EXC_VEC_STRIDE : default byte distance between source vectors
// ----------------------------------------------------------------------------
package exception_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ACK     = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [1:0] ESEL_ELR   = 2'b00;
    localparam logic [1:0] ESEL_ESR   = 2'b01;
    localparam logic [1:0] ESEL_PEND  = 2'b10;
    localparam logic [1:0] ESEL_CAUSE = 2'b11;

    localparam logic [63:0] EXC_VEC_BASE   = 64'hD8;
    localparam logic [63:0] EXC_VEC_STRIDE = 64'h8;

endpackage

// File: rtl/exception_unit_if.sv
// ----------------------------------------------------------------------------
// exception_unit_if
// Bundles every datapath-facing signal of the exception controller.
//   master : datapath side (drives requests, PCs, ERet, read select)
//   slave  : exception_unit side (drives ExcAck, redirect, branch, read data)
// Parameters N (data/address width) and NSRC (source count) must match the
// exception_unit instance this interface is connected to.
// ----------------------------------------------------------------------------
interface exception_unit_if #(
    parameter int N    = 64,
    parameter int NSRC = 4
) ();

    logic [NSRC-1:0]   exc_req;
    logic [NSRC-1:0]   exc_en;
    logic [4*NSRC-1:0] EStatus;
    logic              ERet;
    logic [N-1:0]      NextPC_X;
    logic [N-1:0]      imem_addr_X;
    logic [N-1:0]      ALUBranch_X;
    logic [1:0]        EDataSel;

    logic              ExcAck;
    logic              EProc_X;
    logic [N-1:0]      PCBranch_X;
    logic [N-1:0]      readData_X;
    logic [N-1:0]      EVAddr_X;

    modport master (
        output exc_req, exc_en, EStatus, ERet, NextPC_X, imem_addr_X,
               ALUBranch_X, EDataSel,
        input  ExcAck, EProc_X, PCBranch_X, readData_X, EVAddr_X
    );

    modport slave (
        input  exc_req, exc_en, EStatus, ERet, NextPC_X, imem_addr_X,
               ALUBranch_X, EDataSel,
        output ExcAck, EProc_X, PCBranch_X, readData_X, EVAddr_X
    );

endinterface

// File: rtl/exception_unit_prio_enc.sv
// ----------------------------------------------------------------------------
// exc_prio_enc
// Fixed-priority encoder over the candidate vector; bit 0 wins.
//   cand   in  NSRC          candidate (pending & enabled) sources
//   valid  out 1             at least one candidate set
//   idx    out clog2(NSRC)   index of the winning source
//   onehot out NSRC          one-hot of the winning source
// ----------------------------------------------------------------------------
module exc_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDXW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] cand,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [NSRC-1:0] onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                valid     = 1'b1;
                idx       = IDXW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// ----------------------------------------------------------------------------
// exception_unit
// Exception controller for the single-cycle LEGv8 datapath. Latches NSRC
// request pulses as pending, takes the highest-priority enabled one while in
// RUN, redirects fetch to the per-source vector, saves ELR/ESR/ECAUSE and
// blocks nesting until ERet.
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    exception_unit_if.slave:
//          exc_req/exc_en/EStatus   per-source request, enable, status
//          ERet                     return-from-exception in execute
//          imem_addr_X/NextPC_X     current PC / PC+4
//          ALUBranch_X              branch target from execute
//          EDataSel                 exception-register read select
//          ExcAck                   registered acknowledge (high in ACK)
//          EProc_X/EVAddr_X         fetch redirect and vector address
//          PCBranch_X               branch target into fetch
//          readData_X               selected exception register
// ----------------------------------------------------------------------------
module exception_unit
    import exception_pkg::*;
#(
    parameter int            N          = 64,
    parameter int            NSRC       = 4,
    parameter logic [N-1:0]  VEC_BASE   = N'(EXC_VEC_BASE),
    parameter logic [N-1:0]  VEC_STRIDE = N'(EXC_VEC_STRIDE)
) (
    input logic              clk,
    input logic              reset,
    exception_unit_if.slave  bus
);

    localparam int IDXW = $clog2(NSRC);

    exc_state_t      state_q, state_d;
    logic [NSRC-1:0] pend_q;
    logic [N-1:0]    elr_q;
    logic [3:0]      esr_q;
    logic [IDXW-1:0] ecause_q;
    logic            exc_ack_q;

    logic [NSRC-1:0] cand;
    logic            win_valid;
    logic [IDXW-1:0] win_idx;
    logic [NSRC-1:0] win_onehot;
    logic            take;
    logic [NSRC-1:0] take_onehot;

    assign cand = pend_q & bus.exc_en;

    exc_prio_enc #(
        .NSRC (NSRC),
        .IDXW (IDXW)
    ) u_prio (
        .cand   (cand),
        .valid  (win_valid),
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    // Takes are only allowed from RUN, which is what prevents nesting.
    assign take        = (state_q == RUN) && win_valid;
    assign take_onehot = take ? win_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ERet in ACK short-circuits straight back to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (take)     state_d = ACK;
            ACK:     if (bus.ERet) state_d = RUN;
                     else          state_d = HANDLER;
            HANDLER: if (bus.ERet) state_d = RUN;
            default:               state_d = RUN;
        endcase
    end

    // A new pulse wins over the clear of the bit being taken, so a request
    // arriving on the take cycle for the same source is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            elr_q     <= '0;
            esr_q     <= '0;
            ecause_q  <= '0;
            exc_ack_q <= 1'b0;
        end else begin
            pend_q    <= (pend_q & ~take_onehot) | bus.exc_req;
            exc_ack_q <= take;
            if (take) begin
                elr_q    <= bus.imem_addr_X;
                esr_q    <= bus.EStatus[4*int'(win_idx) +: 4];
                ecause_q <= win_idx;
            end
        end
    end

    assign bus.ExcAck     = exc_ack_q;
    assign bus.EProc_X    = take;
    assign bus.EVAddr_X   = take ? (VEC_BASE + N'(win_idx) * VEC_STRIDE) : VEC_BASE;
    assign bus.PCBranch_X = bus.ERet ? elr_q : bus.ALUBranch_X;

    always_comb begin
        bus.readData_X = '0;
        case (bus.EDataSel)
            ESEL_ELR:   bus.readData_X = elr_q;
            ESEL_ESR:   bus.readData_X = N'(esr_q);
            ESEL_PEND:  bus.readData_X = N'(pend_q);
            ESEL_CAUSE: bus.readData_X = N'(ecause_q);
            default:    bus.readData_X = '0;
        endcase
    end

endmodule
